// File: rtl/axis_pkt_len_tagger.sv
// AXI-Stream pass-through with a 2-entry skid buffer and a per-packet
// byte-length / oversize record on a side-band metadata stream.
`timescale 1ns/1ps
module axis_pkt_len_tagger #(
  parameter int unsigned TDATA_WIDTH   = 512,
  parameter int unsigned LEN_WIDTH     = 16,
  parameter int unsigned MAX_PKT_BYTES = 9000
) (
  input  logic                     s_aclk,
  input  logic                     s_areset,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [LEN_WIDTH-1:0]     m_meta_tdata,
  output logic                     m_meta_tuser,
  output logic                     m_meta_tvalid,
  input  logic                     m_meta_tready,
  output logic [31:0]              pkt_count
);

  localparam int unsigned KEEP_W = TDATA_WIDTH / 8;
  localparam int unsigned BCNT_W = $clog2(KEEP_W + 1);
  localparam int unsigned SUM_W  = ((LEN_WIDTH > BCNT_W) ? LEN_WIDTH : BCNT_W) + 1;
  localparam logic [SUM_W-1:0] LEN_MAX = SUM_W'({LEN_WIDTH{1'b1}});

  function automatic logic [BCNT_W-1:0] popcount(input logic [KEEP_W-1:0] k);
    logic [BCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_W; i++) c = c + BCNT_W'(k[i]);
    return c;
  endfunction

  logic [1:0]             occ;
  logic [TDATA_WIDTH-1:0] spare_data;
  logic [KEEP_W-1:0]      spare_keep;
  logic                   spare_last;
  logic [LEN_WIDTH-1:0]   acc;
  logic                   sat;

  logic                   push;
  logic                   data_pop;
  logic                   meta_pop;
  logic [BCNT_W-1:0]      beat_bytes;
  logic [SUM_W-1:0]       sum;
  logic                   sum_sat;
  logic [LEN_WIDTH-1:0]   acc_next;
  logic                   sat_next;
  logic                   over;

  assign m_axis_tvalid = (occ != 2'd0);
  assign data_pop      = m_axis_tvalid && m_axis_tready;
  assign meta_pop      = m_meta_tvalid && m_meta_tready;
  // A tlast beat only needs the meta slot free, or freed by this cycle's handshake.
  assign s_axis_tready = !s_areset && (occ != 2'd2) &&
                         !(s_axis_tlast && m_meta_tvalid && !m_meta_tready);
  assign push          = s_axis_tvalid && s_axis_tready;

  // Saturating byte accumulator for the packet in flight.
  always_comb begin
    beat_bytes = popcount(s_axis_tkeep);
    sum        = SUM_W'(acc) + SUM_W'(beat_bytes);
    sum_sat    = (sum > LEN_MAX);
    acc_next   = sum_sat ? LEN_WIDTH'(LEN_MAX) : LEN_WIDTH'(sum);
    sat_next   = sat || sum_sat;
    over       = (32'(acc_next) > 32'(MAX_PKT_BYTES));
  end

  // Skid buffer: the head entry drives m_axis directly, spare holds the second beat.
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      occ          <= 2'd0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
      spare_data   <= '0;
      spare_keep   <= '0;
      spare_last   <= 1'b0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            m_axis_tdata <= s_axis_tdata;
            m_axis_tkeep <= s_axis_tkeep;
            m_axis_tlast <= s_axis_tlast;
            occ          <= 2'd1;
          end
        end
        2'd1: begin
          if (push && data_pop) begin
            m_axis_tdata <= s_axis_tdata;
            m_axis_tkeep <= s_axis_tkeep;
            m_axis_tlast <= s_axis_tlast;
          end else if (push) begin
            spare_data <= s_axis_tdata;
            spare_keep <= s_axis_tkeep;
            spare_last <= s_axis_tlast;
            occ        <= 2'd2;
          end else if (data_pop) begin
            occ <= 2'd0;
          end
        end
        2'd2: begin
          if (data_pop) begin
            m_axis_tdata <= spare_data;
            m_axis_tkeep <= spare_keep;
            m_axis_tlast <= spare_last;
            occ          <= 2'd1;
          end
        end
        default: occ <= 2'd0;
      endcase
    end
  end

  // Packet accounting and the single-record meta slot.
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      acc           <= '0;
      sat           <= 1'b0;
      m_meta_tvalid <= 1'b0;
      m_meta_tdata  <= '0;
      m_meta_tuser  <= 1'b0;
      pkt_count     <= '0;
    end else begin
      if (push && s_axis_tlast) begin
        acc           <= '0;
        sat           <= 1'b0;
        m_meta_tvalid <= 1'b1;
        m_meta_tdata  <= acc_next;
        m_meta_tuser  <= sat_next || over;
        pkt_count     <= pkt_count + 32'd1;
      end else begin
        if (push) begin
          acc <= acc_next;
          sat <= sat_next;
        end
        if (meta_pop) m_meta_tvalid <= 1'b0;
      end
    end
  end

endmodule
